uart_xfer_ctrl: RTL and testbench
=================================

Name: uart_xfer_ctrl

Overview:
- Sequences the UART on behalf of the peripheral register block.
- Buffers CPU-written TX bytes in a small FIFO and issues one start pulse per byte when the UART transmitter is idle.
- Captures received bytes into a holding register and tracks valid and overrun status.
- Raises a maskable interrupt toward the peripheral irq logic; sits between the peripheral register decode and the UART core.

Parameters:
- DEPTH, 4, TX FIFO entries; power of 2, at least 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_tx  in  1  CPU write strobe to the TX data register; one cycle per byte.
- tx_wdata  in  8  byte to transmit; sampled when wr_tx=1.
- rd_rx  in  1  CPU read strobe of the RX data register; pops the holding register.
- rx_rdata  out  8  held RX byte.
- rx_ie  in  1  RX interrupt enable.
- tx_ie  in  1  TX-empty interrupt enable.
- clr_err  in  1  clears the sticky error flags.
- TX_STATUS  in  1  UART transmitter idle (1) / busy (0).
- TX_DATA  out  8  byte presented to the UART.
- ctrl  out  1  one-cycle transmit start pulse.
- RX_STATUS  in  1  UART receive-done flag; held high at least 1 cycle per byte.
- RX_DATA  in  8  received byte; valid while RX_STATUS=1.
- tx_full  out  1  FIFO count equals DEPTH.
- tx_empty  out  1  FIFO count is 0 and the TX FSM is in IDLE.
- rx_valid  out  1  rx_rdata holds an unread byte.
- tx_ovf  out  1  sticky: a write arrived while the FIFO was full.
- rx_ovr  out  1  sticky: a byte arrived while rx_valid=1.
- irq  out  1  registered interrupt request.

Behaviour:
- Reset: all outputs and state are 0 except tx_empty, which is 1.
  - This covers rx_rdata, TX_DATA, ctrl, rx_valid, tx_full, tx_ovf, rx_ovr and irq.
  - Pointers and count are 0; FSM is in IDLE; the RX edge register is 0.
  - Reset mid-transfer abandons the FIFO contents; ctrl drops in the same cycle.
- TX FIFO: count is (AW+1) bits. Pointers wrap modulo DEPTH.
  - A write is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - A rejected write sets tx_ovf; the FIFO is unchanged.
  - A simultaneous push and pop leaves count unchanged.
- TX FSM:
  - IDLE: if count>0 and TX_STATUS=1, pop the head into TX_DATA, assert ctrl for exactly 1 cycle, and go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when TX_STATUS=0. If TX_STATUS stays 1 for 15 cycles, return to IDLE; this covers a UART that completes instantly or misses the pulse, and the byte counts as sent.
  - WAIT_DONE: go to IDLE when TX_STATUS=1.
  - TX_DATA holds its value until the next pop.
  - Minimum spacing between ctrl pulses is 3 cycles.
- RX path:
  - Rising edge of RX_STATUS, detected against the registered previous value, loads RX_DATA into rx_rdata and sets rx_valid.
  - If rx_valid=1 and rd_rx=0 in the edge cycle: new data overwrites and rx_ovr is set.
  - Edge and rd_rx in the same cycle: new data is loaded, rx_valid stays 1, no overrun.
  - rd_rx with no edge clears rx_valid next cycle; rd_rx while rx_valid=0 has no effect.
- Errors: clr_err clears tx_ovf and rx_ovr. If a new error event occurs in the same cycle, the set wins.
- irq: registered (rx_ie & rx_valid) | (tx_ie & tx_empty), so it lags its cause by 1 cycle.
- Status flags tx_full and tx_empty are registered and update in the cycle after the push or pop.

Test Plan:
- Reset, then write 0x41, 0x42 back-to-back with TX_STATUS=1; the UART model goes busy 2 cycles after ctrl for 10 cycles -> ctrl pulses with TX_DATA=0x41 and then 0x42, in order, each 1 cycle wide; tx_empty returns to 1 after the second done.
- Hold TX_STATUS=0 and write 5 bytes (DEPTH=4) -> tx_full=1 after the 4th; the 5th sets tx_ovf; release TX_STATUS -> exactly 4 bytes go out; clr_err clears tx_ovf.
- Drive an RX_STATUS pulse with RX_DATA=0x5A -> rx_valid=1, rx_rdata=0x5A; with rx_ie=1, irq=1 one cycle later; rd_rx -> rx_valid=0 and irq drops.
- Second RX byte 0x33 arrives while unread -> rx_rdata=0x33 and rx_ovr=1; repeat with rd_rx coincident with the edge -> no rx_ovr, rx_valid stays 1.
- Never drop TX_STATUS after ctrl -> FSM returns to IDLE after 15 cycles and the next queued byte is sent.
- Assert reset during WAIT_DONE with 2 bytes queued -> next cycle the count is 0, tx_empty=1, no further ctrl pulse.

Source files
------------

// File: rtl/uart_xfer_ctrl.sv
// uart_xfer_ctrl: buffers CPU TX bytes in a small FIFO and starts the UART
// transmitter one byte at a time. It also captures received bytes with
// valid/overrun tracking and raises a maskable registered interrupt.
module uart_xfer_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_tx,
    input  logic [7:0] tx_wdata,
    input  logic       rd_rx,
    output logic [7:0] rx_rdata,
    input  logic       rx_ie,
    input  logic       tx_ie,
    input  logic       clr_err,
    input  logic       TX_STATUS,
    output logic [7:0] TX_DATA,
    output logic       ctrl,
    input  logic       RX_STATUS,
    input  logic [7:0] RX_DATA,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       rx_valid,
    output logic       tx_ovf,
    output logic       rx_ovr,
    output logic       irq
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    // WAIT_BUSY gives up after 15 cycles of TX_STATUS=1 (counter values 0..14)
    localparam logic [3:0]  TO_LAST = 4'd14;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    to_cnt_q, to_cnt_d;
    logic [7:0]    tx_data_q, rx_rdata_q;
    logic          ctrl_q, tx_full_q, tx_empty_q, rx_valid_q;
    logic          tx_ovf_q, rx_ovr_q, irq_q, rx_prev_q;
    logic          pop, push, rx_edge;

    // A pop happens only from IDLE with data queued and the UART idle; a full
    // FIFO can still take a write in the same cycle it pops.
    assign pop     = (state_q == S_IDLE) && (count_q != '0) && TX_STATUS;
    assign push    = wr_tx && ((count_q != DEPTH_C) || pop);
    assign rx_edge = RX_STATUS && !rx_prev_q;

    // Next FIFO occupancy
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // TX sequencing FSM with a give-up timer in WAIT_BUSY
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d  = S_WAIT_BUSY;
                    to_cnt_d = '0;
                end
            end
            S_WAIT_BUSY: begin
                if (!TX_STATUS)             state_d = S_WAIT_DONE;
                else if (to_cnt_q == TO_LAST) state_d = S_IDLE;
                else                        to_cnt_d = to_cnt_q + 1'b1;
            end
            S_WAIT_DONE: begin
                if (TX_STATUS) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO storage, pointers, FSM state and registered TX status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            to_cnt_q   <= '0;
            tx_data_q  <= '0;
            ctrl_q     <= 1'b0;
            tx_full_q  <= 1'b0;
            tx_empty_q <= 1'b1;
            tx_ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= tx_wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                tx_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            ctrl_q     <= pop;
            tx_full_q  <= (count_d == DEPTH_C);
            tx_empty_q <= (count_d == '0) && (state_d == S_IDLE);
            // a new rejected write beats a clear in the same cycle
            if (wr_tx && !push) tx_ovf_q <= 1'b1;
            else if (clr_err)   tx_ovf_q <= 1'b0;
        end
    end

    // RX capture: load on the rising edge of RX_STATUS, track valid/overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_prev_q  <= 1'b0;
            rx_rdata_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_prev_q <= RX_STATUS;
            if (rx_edge) begin
                rx_rdata_q <= RX_DATA;
                rx_valid_q <= 1'b1;
            end else if (rd_rx) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_edge && rx_valid_q && !rd_rx) rx_ovr_q <= 1'b1;
            else if (clr_err)                    rx_ovr_q <= 1'b0;
        end
    end

    // Interrupt request, registered from the current status flags
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= (rx_ie && rx_valid_q) || (tx_ie && tx_empty_q);
    end

    // ctrl is gated so a reset cuts a start pulse off immediately
    assign ctrl     = ctrl_q && !reset;
    assign TX_DATA  = tx_data_q;
    assign rx_rdata = rx_rdata_q;
    assign tx_full  = tx_full_q;
    assign tx_empty = tx_empty_q;
    assign rx_valid = rx_valid_q;
    assign tx_ovf   = tx_ovf_q;
    assign rx_ovr   = rx_ovr_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_uart_xfer_ctrl.sv
// Bench for uart_xfer_ctrl: a UART transmitter model answers start pulses, a
// monitor records every pulse, and each scenario task checks the recorded
// pulses and the status outputs against a queue-based model of the spec.
module tb_uart_xfer_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_tx = 1'b0, rd_rx = 1'b0, rx_ie = 1'b0, tx_ie = 1'b0, clr_err = 1'b0;
    logic [7:0] tx_wdata = '0, RX_DATA = '0;
    logic       TX_STATUS = 1'b1, RX_STATUS = 1'b0;
    logic [7:0] rx_rdata, TX_DATA;
    logic       ctrl, tx_full, tx_empty, rx_valid, tx_ovf, rx_ovr, irq;

    int errors = 0;
    int checks = 0;

    // UART model controls: mode 0 answers ctrl, mode 1 never leaves idle
    int uart_mode = 0;
    bit uart_hold = 1'b0;

    // model / scoreboard state
    logic [7:0] exp_q[$];   // accepted TX bytes in order
    logic [7:0] got_q[$];   // bytes seen at each ctrl pulse
    int         got_cyc[$];
    int         wide_cnt = 0;
    int         cyc = 0;
    bit         m_valid, m_ovr;
    logic [7:0] m_data;

    uart_xfer_ctrl #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .reset(reset), .wr_tx(wr_tx), .tx_wdata(tx_wdata),
        .rd_rx(rd_rx), .rx_rdata(rx_rdata), .rx_ie(rx_ie), .tx_ie(tx_ie),
        .clr_err(clr_err), .TX_STATUS(TX_STATUS), .TX_DATA(TX_DATA),
        .ctrl(ctrl), .RX_STATUS(RX_STATUS), .RX_DATA(RX_DATA),
        .tx_full(tx_full), .tx_empty(tx_empty), .rx_valid(rx_valid),
        .tx_ovf(tx_ovf), .rx_ovr(rx_ovr), .irq(irq)
    );

    always #5 clk = ~clk;

    // UART transmitter: busy 2 cycles after ctrl, for 10 cycles
    initial begin
        int dly, busy;
        dly = 0; busy = 0;
        forever begin
            @(posedge clk); #1;
            if (uart_mode == 0 && ctrl) dly = 2;
            else if (dly > 0) begin
                dly--;
                if (dly == 0) busy = 10;
            end
            if (busy > 0) begin
                TX_STATUS = 1'b0;
                busy--;
            end else TX_STATUS = !uart_hold;
        end
    end

    // pulse recorder
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(posedge clk); #2;
            cyc++;
            if (ctrl) begin
                if (prev) wide_cnt++;
                got_q.push_back(TX_DATA);
                got_cyc.push_back(cyc);
            end
            prev = ctrl;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // drive one write; the model accepts it only if the FIFO has room
    task automatic push(input logic [7:0] b);
        wr_tx = 1'b1;
        tx_wdata = b;
        if (exp_q.size() - got_q.size() < DEPTH) exp_q.push_back(b);
        tick();
    endtask

    task automatic wait_pulses(input int n, input int limit);
        for (int k = 0; k < limit && got_q.size() < n; k++) tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if ({rx_rdata, TX_DATA} !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", {rx_rdata, TX_DATA}); end
        checks++; if ({ctrl, tx_full, tx_empty, rx_valid, tx_ovf, rx_ovr, irq} !== 7'b0010000) begin errors++;
            $display("FAIL reset_flags: got %b want 0010000", {ctrl, tx_full, tx_empty, rx_valid, tx_ovf, rx_ovr, irq}); end
        reset = 1'b0;
        tx_ie = 1'b1;
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
        tx_ie = 1'b0;
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tx_masked: got %b want 0", irq); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = got_q.size();
        push(8'h41);
        push(8'h42);
        wr_tx = 1'b0;
        checks++; if (tx_empty !== 1'b0) begin errors++; $display("FAIL b2b_busy_empty: got %b want 0", tx_empty); end
        wait_pulses(base + 2, 100);
        checks++; if (got_q.size() !== base + 2) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), base + 2); end
        else begin
            checks++; if ({got_q[base], got_q[base+1]} !== 16'h4142) begin errors++;
                $display("FAIL b2b_data: got %h%h want 4142", got_q[base], got_q[base+1]); end
            checks++; if (got_cyc[base+1] - got_cyc[base] < 3) begin errors++;
                $display("FAIL b2b_spacing: got %0d want >=3", got_cyc[base+1] - got_cyc[base]); end
        end
        checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL b2b_width: got %0d wide pulses want 0", wide_cnt); end
        for (int k = 0; k < 50 && tx_empty !== 1'b1; k++) tick();
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty_after: got %b want 1", tx_empty); end
    endtask

    task automatic test_overflow();
        int base;
        uart_hold = 1'b1;
        repeat (3) tick();
        base = got_q.size();
        for (int i = 0; i < 5; i++) begin
            push(8'($urandom));
            if (i == 3) begin
                checks++; if ({tx_full, tx_ovf} !== 2'b10) begin errors++; $display("FAIL ovf_full4: got %b want 10", {tx_full, tx_ovf}); end
            end
        end
        wr_tx = 1'b0;
        checks++; if ({tx_full, tx_ovf} !== 2'b11) begin errors++; $display("FAIL ovf_fifth: got %b want 11", {tx_full, tx_ovf}); end
        uart_hold = 1'b0;
        wait_pulses(base + 4, 200);
        repeat (40) tick();
        checks++; if (got_q.size() !== base + 4) begin errors++; $display("FAIL ovf_sent: got %0d want %0d", got_q.size() - base, 4); end
        for (int i = base; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_data%0d: got %h want %h", i - base, got_q[i], exp_q[i]); end
        end
        checks++; if (tx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", tx_ovf); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (tx_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", tx_ovf); end
    endtask

    task automatic test_random_tx();
        int base, n;
        base = got_q.size();
        n = $urandom_range(5, 9);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            for (int k = 0; k < 100 && exp_q.size() - got_q.size() >= DEPTH; k++) tick();
            push(8'($urandom));
            wr_tx = 1'b0;
        end
        wait_pulses(exp_q.size(), 500);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = base; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_data%0d: got %h want %h", i - base, got_q[i], exp_q[i]); end
            if (i > base) begin
                checks++; if (got_cyc[i] - got_cyc[i-1] < 3) begin errors++; $display("FAIL rnd_spacing%0d: got %0d want >=3", i - base, got_cyc[i] - got_cyc[i-1]); end
            end
        end
        checks++; if (tx_ovf !== 1'b0) begin errors++; $display("FAIL rnd_no_ovf: got %b want 0", tx_ovf); end
    endtask

    task automatic test_rx();
        logic [7:0] b;
        rx_ie = 1'b1;
        RX_DATA = 8'h5A; RX_STATUS = 1'b1;
        tick();
        checks++; if ({rx_valid, rx_rdata, irq} !== {1'b1, 8'h5A, 1'b0}) begin errors++;
            $display("FAIL rx_load: got v=%b d=%h irq=%b want v=1 d=5a irq=0", rx_valid, rx_rdata, irq); end
        RX_STATUS = 1'b0;
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq: got %b want 1", irq); end
        rd_rx = 1'b1;
        tick();
        rd_rx = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_read: got %b want 0", rx_valid); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_drop: got %b want 0", irq); end
        // overrun
        RX_DATA = 8'($urandom); RX_STATUS = 1'b1; tick();
        RX_STATUS = 1'b0; tick();
        RX_DATA = 8'h33; RX_STATUS = 1'b1; tick();
        RX_STATUS = 1'b0;
        checks++; if ({rx_valid, rx_rdata, rx_ovr} !== {1'b1, 8'h33, 1'b1}) begin errors++;
            $display("FAIL rx_overrun: got v=%b d=%h ovr=%b want v=1 d=33 ovr=1", rx_valid, rx_rdata, rx_ovr); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++; if (rx_ovr !== 1'b0) begin errors++; $display("FAIL rx_ovr_clear: got %b want 0", rx_ovr); end
        // edge coincident with read: no overrun, stays valid
        b = 8'($urandom);
        RX_DATA = b; RX_STATUS = 1'b1; rd_rx = 1'b1; tick();
        RX_STATUS = 1'b0; rd_rx = 1'b0;
        checks++; if ({rx_valid, rx_rdata, rx_ovr} !== {1'b1, b, 1'b0}) begin errors++;
            $display("FAIL rx_rd_edge: got v=%b d=%h ovr=%b want v=1 d=%h ovr=0", rx_valid, rx_rdata, rx_ovr, b); end
        tick();
        // overrun and clear in the same cycle: set wins
        b = 8'($urandom);
        RX_DATA = b; RX_STATUS = 1'b1; clr_err = 1'b1; tick();
        RX_STATUS = 1'b0; clr_err = 1'b0;
        checks++; if ({rx_ovr, rx_rdata} !== {1'b1, b}) begin errors++;
            $display("FAIL rx_set_wins: got ovr=%b d=%h want ovr=1 d=%h", rx_ovr, rx_rdata, b); end
        clr_err = 1'b1; rd_rx = 1'b1; tick(); clr_err = 1'b0;
        tick(); rd_rx = 1'b0;   // read while already empty: no effect
        checks++; if ({rx_valid, rx_ovr, rx_rdata} !== {2'b00, b}) begin errors++;
            $display("FAIL rx_empty_read: got v=%b ovr=%b d=%h want v=0 ovr=0 d=%h", rx_valid, rx_ovr, rx_rdata, b); end
        rx_ie = 1'b0;
        // randomized byte/read events against the rule-level model
        m_valid = 1'b0; m_ovr = 1'b0; m_data = b;
        for (int i = 0; i < 20; i++) begin
            bit arrive, rd;
            logic [7:0] nb;
            arrive = 1'($urandom); rd = 1'($urandom); nb = 8'($urandom);
            RX_DATA = nb; RX_STATUS = arrive; rd_rx = rd;
            tick();
            if (arrive) begin
                if (m_valid && !rd) m_ovr = 1'b1;
                m_data = nb; m_valid = 1'b1;
            end else if (rd) m_valid = 1'b0;
            RX_STATUS = 1'b0; rd_rx = 1'b0; RX_DATA = 8'($urandom);
            checks++; if ({rx_valid, rx_ovr, rx_rdata} !== {m_valid, m_ovr, m_data}) begin errors++;
                $display("FAIL rx_rand%0d: got v=%b ovr=%b d=%h want v=%b ovr=%b d=%h", i, rx_valid, rx_ovr, rx_rdata, m_valid, m_ovr, m_data); end
            tick();
        end
        clr_err = 1'b1; rd_rx = 1'b1; tick(); clr_err = 1'b0; rd_rx = 1'b0;
    endtask

    // UART never goes busy: the controller gives up after 15 idle cycles in
    // WAIT_BUSY, so pulses are 16 cycles apart (1 ctrl cycle + 15 waiting).
    task automatic test_timeout();
        int base;
        uart_mode = 1;
        repeat (15) tick();
        base = got_q.size();
        push(8'($urandom));
        push(8'($urandom));
        wr_tx = 1'b0;
        wait_pulses(base + 2, 100);
        checks++; if (got_q.size() !== base + 2) begin errors++; $display("FAIL to_count: got %0d want %0d", got_q.size() - base, 2); end
        else begin
            checks++; if (got_cyc[base+1] - got_cyc[base] !== 16) begin errors++;
                $display("FAIL to_gap: got %0d want 16", got_cyc[base+1] - got_cyc[base]); end
            checks++; if (got_q[base+1] !== exp_q[base+1]) begin errors++;
                $display("FAIL to_data: got %h want %h", got_q[base+1], exp_q[base+1]); end
        end
        uart_mode = 0;
        repeat (5) tick();
    endtask

    task automatic test_reset_mid();
        int base;
        base = got_q.size();
        push(8'($urandom));
        push(8'($urandom));
        push(8'($urandom));
        wr_tx = 1'b0;
        wait_pulses(base + 1, 50);
        repeat (4) tick();   // UART now busy: controller waiting for done
        reset = 1'b1;
        tick();
        checks++; if ({ctrl, tx_empty, tx_full} !== 3'b010) begin errors++;
            $display("FAIL rst_mid_flags: got %b want 010", {ctrl, tx_empty, tx_full}); end
        reset = 1'b0;
        while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        repeat (40) tick();
        checks++; if (got_q.size() !== base + 1) begin errors++; $display("FAIL rst_mid_pulses: got %0d want 1", got_q.size() - base); end
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty: got %b want 1", tx_empty); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_random_tx();
        test_rx();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
